// File: rtl/avalon_multi_timer_pkg.sv
// Shared definitions for the multi-channel interval timer.
// Holds the per-channel register offsets, control/status bit positions,
// the prescaler field range and the packed control-register layout.
package avalon_multi_timer_pkg;

  // Register offset within a channel (address[1:0]).
  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } reg_sel_e;

  // CONTROL bit positions.
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  // CONTROL prescaler field.
  localparam int PRESC_LSB = 8;
  localparam int PRESC_MSB = 15;
  localparam int PRESC_W   = PRESC_MSB - PRESC_LSB + 1;

  // STATUS bit positions.
  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  // Persistent (readable) part of CONTROL; START/STOP are pulses only.
  typedef struct packed {
    logic [PRESC_W-1:0] presc;
    logic               cont;
    logic               ito;
  } ctrl_t;

  // Extract the persistent control fields from a bus write.
  function automatic ctrl_t ctrl_decode(input logic [31:0] word);
    ctrl_t c;
    c.ito   = word[CTL_ITO];
    c.cont  = word[CTL_CONT];
    c.presc = word[PRESC_MSB:PRESC_LSB];
    return c;
  endfunction

  // Build the CONTROL readback word; START/STOP positions read 0.
  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    logic [31:0] word;
    word                      = '0;
    word[CTL_ITO]             = c.ito;
    word[CTL_CONT]            = c.cont;
    word[PRESC_MSB:PRESC_LSB] = c.presc;
    return word;
  endfunction

endpackage

// File: rtl/avalon_multi_timer_channel.sv
// One timer channel: 8-bit prescaler, CNT_W-bit down-counter with period
// reload, RUN/TO flags and a snapshot register.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   wr             write strobe already qualified for this channel
//   reg_sel        register offset of the current bus address
//   writedata      bus write data
//   rdata          read value of the selected register (combinational)
//   irq            TO & ITO
module timer_channel
  import avalon_multi_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 9999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr,
  input  reg_sel_e    reg_sel,
  input  logic [31:0] writedata,
  output logic [31:0] rdata,
  output logic        irq
);

  ctrl_t              ctrl;
  logic               run;
  logic               to;
  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   counter;
  logic [CNT_W-1:0]   snapshot;
  logic [PRESC_W-1:0] pcnt;
  logic               reload_pend;
  logic               zero_q;

  logic we_status;
  logic we_control;
  logic we_period;
  logic we_snap;
  logic start;
  logic stop;
  logic tick;
  logic at_zero;
  logic timeout;

  // Status and snapshot writes ignore the data; narrow counters leave
  // upper period bits unused.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign we_status  = wr && (reg_sel == REG_STATUS);
  assign we_control = wr && (reg_sel == REG_CONTROL);
  assign we_period  = wr && (reg_sel == REG_PERIOD);
  assign we_snap    = wr && (reg_sel == REG_SNAP);

  assign start   = we_control && writedata[CTL_START];
  assign stop    = we_control && writedata[CTL_STOP];
  assign tick    = run && (pcnt == ctrl.presc);
  assign at_zero = (counter == '0);
  // Edge on reaching zero: a counter parked at 0 raises only one event.
  assign timeout = at_zero && !zero_q;

  assign irq = to && ctrl.ito;

  // NOTE: state updates use non-blocking assignments so every register in
  // this block samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl        <= '0;
      run         <= 1'b0;
      to          <= 1'b0;
      period      <= CNT_W'(RESET_PERIOD);
      counter     <= CNT_W'(RESET_PERIOD);
      snapshot    <= '0;
      pcnt        <= '0;
      reload_pend <= 1'b0;
      zero_q      <= (RESET_PERIOD == 0);
    end else begin
      zero_q <= at_zero;

      // A fresh timeout beats a simultaneous clear so no event is lost.
      if (timeout)        to <= 1'b1;
      else if (we_status) to <= 1'b0;

      if (we_control) ctrl <= ctrl_decode(writedata);

      // The period write lands now; the forced reload follows one cycle
      // later from the freshly written value.
      if (we_period) period <= writedata[CNT_W-1:0];
      reload_pend <= we_period;

      if (we_snap) snapshot <= counter;

      if (reload_pend) begin
        counter <= period;
      end else if (tick) begin
        if (!at_zero)  counter <= counter - CNT_W'(1);
        else if (ctrl.cont) counter <= period;
      end

      if (reload_pend || start || tick) pcnt <= '0;
      else                              pcnt <= pcnt + PRESC_W'(1);

      // START wins over STOP and over the reload's implicit stop.
      if (start)                                 run <= 1'b1;
      else if (stop || reload_pend)              run <= 1'b0;
      else if (tick && at_zero && !ctrl.cont)    run <= 1'b0;
    end
  end

  // NOTE: rdata gets a default before the case so no path infers a latch.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_STATUS: begin
        rdata[ST_TO]  = to;
        rdata[ST_RUN] = run;
      end
      REG_CONTROL: rdata = ctrl_word(ctrl);
      REG_PERIOD:  rdata[CNT_W-1:0] = period;
      REG_SNAP:    rdata[CNT_W-1:0] = snapshot;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: rtl/avalon_multi_timer.sv
// Multi-channel interval timer behind one Avalon-MM slave.
// Word address = {channel, reg}; each channel is a timer_channel instance.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   address        {channel index, register offset}
//   chipselect     slave select
//   write_n        active-low write strobe
//   writedata      32-bit write data
//   readdata       registered read data (1-cycle latency)
//   irq            OR of irq_vec
//   irq_vec        per-channel TO & ITO
module avalon_multi_timer
  import avalon_multi_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 9999
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [$clog2(NUM_CH)+1:0]   address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic                        irq,
  output logic [NUM_CH-1:0]           irq_vec
);

  logic        wr_strobe;
  logic [7:0]  ch_idx;
  reg_sel_e    reg_sel;
  logic [31:0] ch_rdata [NUM_CH];
  logic [31:0] rd_mux;

  assign wr_strobe = chipselect && !write_n;
  // Channel field widened to a byte; indices >= NUM_CH match no channel,
  // so they read 0 and their writes go nowhere.
  assign ch_idx    = 8'(address >> 2);
  assign reg_sel   = reg_sel_e'(address[1:0]);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_W        (CNT_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr        (wr_strobe && (ch_idx == 8'(g))),
      .reg_sel   (reg_sel),
      .writedata (writedata),
      .rdata     (ch_rdata[g]),
      .irq       (irq_vec[g])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 8'(i)) rd_mux = ch_rdata[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Directed bench for avalon_multi_timer (NUM_CH=4, CNT_W=32).
// Inputs change on the falling edge; outputs are sampled on the falling
// edge. Register reads push their expectation to a scoreboard queue and
// pop it when readdata arrives one cycle later.
module tb_avalon_multi_timer;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int AW     = 4;

  localparam int R_ST  = 0;
  localparam int R_CTL = 1;
  localparam int R_PER = 2;
  localparam int R_SNP = 3;

  logic              clk;
  logic              reset_n;
  logic [AW-1:0]     address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  avalon_multi_timer #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .RESET_PERIOD (9999)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [AW-1:0] ad(input int ch, input int r);
    return AW'(ch * 4 + r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called and returns on a falling edge; the write lands on the rising
  // edge in between.
  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input string tag, input logic [31:0] exp);
    sb_t e;
    address = a;
    e.tag   = tag;
    e.exp   = exp;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, readdata, e.exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(negedge clk);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_irq_vec", 32'(irq_vec), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // ---- reset values of ch0, 1-cycle read latency
    rd(ad(0, R_ST), "ch0_status_rst", 32'd0);
    address = ad(0, R_PER);
    #1;
    check("read_lat_not_early", readdata, 32'd0);
    @(negedge clk);
    check("ch0_period_rst", readdata, 32'd9999);
    rd(ad(0, R_CTL), "ch0_control_rst", 32'd0);
    rd(ad(0, R_SNP), "ch0_snap_rst", 32'd0);

    // ---- ch1 continuous, PERIOD 4, PRESC 0: TO every 5 clocks
    wr(ad(1, R_PER), 32'd4);
    wr(ad(1, R_CTL), 32'h0007);      // START lands with the reload
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("ch1_quiet_%0d", k), 32'(irq_vec[1]), 32'd0);
    end
    @(negedge clk);
    check("ch1_to_first", 32'(irq_vec[1]), 32'd1);
    check("ch1_irq_first", 32'(irq), 32'd1);
    wr(ad(1, R_ST), 32'd0);
    check("ch1_to_cleared", 32'(irq_vec[1]), 32'd0);
    check("ch1_irq_cleared", 32'(irq), 32'd0);
    for (int k = 7; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("ch1_quiet_%0d", k), 32'(irq_vec[1]), 32'd0);
    end
    @(negedge clk);
    check("ch1_to_second", 32'(irq_vec[1]), 32'd1);

    // ---- STATUS write coinciding with a ch1 timeout event
    wr(ad(1, R_ST), 32'd0);
    check("ch1_clear_again", 32'(irq_vec[1]), 32'd0);
    repeat (3) @(negedge clk);
    check("ch1_before_coincide", 32'(irq_vec[1]), 32'd0);
    wr(ad(1, R_ST), 32'd0);          // same edge as the event's TO set
    check("ch1_to_coincide", 32'(irq_vec[1]), 32'd1);
    rd(ad(1, R_ST), "ch1_status_coincide", 32'd3);
    wr(ad(1, R_CTL), 32'h0008);
    wr(ad(1, R_ST), 32'd0);
    rd(ad(1, R_ST), "ch1_status_stopped", 32'd0);

    // ---- ch2 one-shot, PERIOD 3, PRESC 2
    wr(ad(2, R_PER), 32'd3);
    wr(ad(2, R_CTL), 32'h0205);
    for (int t = 1; t <= 9; t++) begin
      @(negedge clk);
      check($sformatf("ch2_quiet_%0d", t), 32'(irq_vec[2]), 32'd0);
    end
    @(negedge clk);
    check("ch2_to", 32'(irq_vec[2]), 32'd1);
    repeat (2) @(negedge clk);       // final tick at zero clears RUN
    rd(ad(2, R_ST), "ch2_status_done", 32'd1);
    rd(ad(2, R_CTL), "ch2_control_readback", 32'h0201);
    wr(ad(2, R_SNP), 32'd0);
    rd(ad(2, R_SNP), "ch2_counter_held", 32'd0);
    wr(ad(2, R_ST), 32'd0);
    repeat (30) @(negedge clk);
    check("ch2_no_more_events", 32'(irq_vec[2]), 32'd0);
    rd(ad(2, R_ST), "ch2_status_idle", 32'd0);

    // ---- ch0 (period 10) and ch3 (period 7) together
    wr(ad(0, R_PER), 32'd10);
    wr(ad(3, R_PER), 32'd7);
    wr(ad(0, R_CTL), 32'h0007);      // ch0 starts at edge S
    wr(ad(3, R_CTL), 32'h0007);      // ch3 starts at edge S+1
    for (int t = 1; t <= 11; t++) begin
      if (t > 1) @(negedge clk);
      check($sformatf("mix_ch0_t%0d", t), 32'(irq_vec[0]), 32'(t >= 11));
      check($sformatf("mix_ch3_t%0d", t), 32'(irq_vec[3]), 32'(t >= 9));
      check($sformatf("mix_irq_t%0d", t), 32'(irq), 32'(t >= 9));
    end
    wr(ad(3, R_ST), 32'd0);
    wr(ad(0, R_ST), 32'd0);
    for (int t = 13; t <= 22; t++) begin
      if (t > 13) @(negedge clk);
      check($sformatf("mix_ch0_t%0d", t), 32'(irq_vec[0]), 32'(t >= 22));
      check($sformatf("mix_ch3_t%0d", t), 32'(irq_vec[3]), 32'(t >= 17));
      check($sformatf("mix_irq_t%0d", t), 32'(irq), 32'(t >= 17));
    end
    wr(ad(3, R_CTL), 32'h0008);
    wr(ad(3, R_ST), 32'd0);

    // ---- snapshot, period rewrite and START|STOP on running ch0
    // ch0 reloaded 10 at S+22; counter is 8 going into edge S+25.
    wr(ad(0, R_SNP), 32'd0);
    rd(ad(0, R_SNP), "ch0_snapshot_live", 32'd8);
    wr(ad(0, R_PER), 32'd100);
    @(negedge clk);                  // reload edge
    wr(ad(0, R_SNP), 32'd0);
    rd(ad(0, R_SNP), "ch0_counter_reloaded", 32'd100);
    rd(ad(0, R_ST), "ch0_status_stopped", 32'd1);
    rd(ad(0, R_PER), "ch0_period_new", 32'd100);
    wr(ad(0, R_CTL), 32'h000C);
    rd(ad(0, R_ST), "ch0_start_wins", 32'd3);
    rd(ad(0, R_CTL), "ch0_control_pulses_read0", 32'd0);
    check("irq_all_masked", 32'(irq), 32'd0);

    // ---- ch1 PERIOD 0 continuous: exactly one event
    wr(ad(1, R_PER), 32'd0);
    wr(ad(1, R_CTL), 32'h0007);
    check("ch1_p0_pre", 32'(irq_vec[1]), 32'd0);
    @(negedge clk);
    check("ch1_p0_event", 32'(irq_vec[1]), 32'd1);
    wr(ad(1, R_ST), 32'd0);
    repeat (20) @(negedge clk);
    check("ch1_p0_no_repeat", 32'(irq_vec[1]), 32'd0);
    rd(ad(1, R_ST), "ch1_p0_status", 32'd2);
    wr(ad(1, R_CTL), 32'h0008);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
